// File: rtl/model_vector_fixed_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | model_vector_fixed_sequencer: feeds A/B vectors element-wise to a vector  |
// | operator and collects its results.                    Revision: 1.0       |
// +--------------------------------------------------------------------------+
module model_vector_fixed_sequencer #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int ADDRESS_SIZE = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  output logic                    BUSY,
  input  logic [DATA_SIZE-1:0]    SIZE_IN,
  input  logic                    LOAD_A_ENABLE,
  input  logic                    LOAD_B_ENABLE,
  input  logic [ADDRESS_SIZE-1:0] LOAD_ADDRESS,
  input  logic [DATA_SIZE-1:0]    LOAD_DATA,
  input  logic [ADDRESS_SIZE-1:0] READ_ADDRESS,
  output logic [DATA_SIZE-1:0]    READ_DATA,
  output logic                    OP_START,
  output logic [DATA_SIZE-1:0]    OP_SIZE_OUT,
  output logic                    OP_DATA_A_OUT_ENABLE,
  output logic                    OP_DATA_B_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    OP_DATA_A_OUT,
  output logic [DATA_SIZE-1:0]    OP_DATA_B_OUT,
  input  logic                    OP_DATA_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    OP_DATA_IN
);

  localparam int                   c_DEPTH   = 1 << ADDRESS_SIZE;
  localparam logic [DATA_SIZE-1:0] c_DEPTH_W = DATA_SIZE'(c_DEPTH);
  localparam int                   c_CMP_W   = (DATA_SIZE > CONTROL_SIZE) ? DATA_SIZE : CONTROL_SIZE;

  typedef enum logic [1:0] {
    IDLE_STATE  = 2'd0,
    ISSUE_STATE = 2'd1,
    WAIT_STATE  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [CONTROL_SIZE-1:0]  r_index;
  logic [DATA_SIZE-1:0]     r_size;
  logic                     r_ready;
  logic                     r_busy;
  logic                     r_op_start;
  logic                     r_op_en;
  logic [DATA_SIZE-1:0]     r_a_out;
  logic [DATA_SIZE-1:0]     r_b_out;
  logic [DATA_SIZE-1:0]     r_read_data;

  logic [DATA_SIZE-1:0]     r_a   [c_DEPTH];
  logic [DATA_SIZE-1:0]     r_b   [c_DEPTH];
  logic [DATA_SIZE-1:0]     r_res [c_DEPTH];

  logic                     w_accept;
  logic                     w_zero_start;
  logic                     w_issue;
  logic                     w_capture;
  logic                     w_last;
  logic [DATA_SIZE-1:0]     w_eff_size;
  logic [ADDRESS_SIZE-1:0]  w_addr;

  assign w_addr     = r_index[ADDRESS_SIZE-1:0];
  assign w_eff_size = (SIZE_IN > c_DEPTH_W) ? c_DEPTH_W : SIZE_IN;
  assign w_last     = (c_CMP_W'(r_index) == (c_CMP_W'(r_size) - c_CMP_W'(1)));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_zero_start = 1'b0;
    w_issue      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE_STATE: begin
        if (START) begin
          if (SIZE_IN != '0) begin
            w_accept     = 1'b1;
            w_state_next = ISSUE_STATE;
          end else begin
            w_zero_start = 1'b1;
          end
        end
      end
      ISSUE_STATE: begin
        w_issue      = 1'b1;
        w_state_next = WAIT_STATE;
      end
      WAIT_STATE: begin
        if (OP_DATA_IN_ENABLE) begin
          w_capture    = 1'b1;
          w_state_next = w_last ? IDLE_STATE : ISSUE_STATE;
        end
      end
      default: w_state_next = IDLE_STATE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE_STATE;
      r_index     <= '0;
      r_size      <= '0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_op_start  <= 1'b0;
      r_op_en     <= 1'b0;
      r_a_out     <= '0;
      r_b_out     <= '0;
      r_read_data <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ready     <= w_zero_start | (w_capture & w_last);
      r_op_start  <= w_accept;
      r_op_en     <= w_issue;
      r_read_data <= r_res[READ_ADDRESS];
      if (w_accept) begin
        r_size  <= w_eff_size;
        r_index <= '0;
        r_busy  <= 1'b1;
      end
      if (w_issue) begin
        r_a_out <= r_a[w_addr];
        r_b_out <= r_b[w_addr];
      end
      if (w_capture) begin
        if (w_last) r_busy  <= 1'b0;
        else        r_index <= r_index + CONTROL_SIZE'(1);
      end
    end
  end

  // Storage is not reset; loads are only honoured while idle so a run sees frozen operands.
  always_ff @(posedge CLK) begin
    if (!RST && (r_state == IDLE_STATE)) begin
      if (LOAD_A_ENABLE) r_a[LOAD_ADDRESS] <= LOAD_DATA;
      if (LOAD_B_ENABLE) r_b[LOAD_ADDRESS] <= LOAD_DATA;
    end
    if (!RST && w_capture) r_res[w_addr] <= OP_DATA_IN;
  end

  assign READY                = r_ready;
  assign BUSY                 = r_busy;
  assign OP_START             = r_op_start;
  assign OP_SIZE_OUT          = r_size;
  assign OP_DATA_A_OUT_ENABLE = r_op_en;
  assign OP_DATA_B_OUT_ENABLE = r_op_en;
  assign OP_DATA_A_OUT        = r_a_out;
  assign OP_DATA_B_OUT        = r_b_out;
  assign READ_DATA            = r_read_data;

endmodule
`default_nettype wire

// File: tb/tb_model_vector_fixed_sequencer.sv
`default_nettype none
// Bench for model_vector_fixed_sequencer: a quotient-returning operator model
// answers each element pair; runs are checked against a vector-level model.
module tb_model_vector_fixed_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        READY, BUSY;
  logic [63:0] SIZE_IN = '0;
  logic        LOAD_A_ENABLE = 1'b0, LOAD_B_ENABLE = 1'b0;
  logic [3:0]  LOAD_ADDRESS = '0;
  logic [63:0] LOAD_DATA = '0;
  logic [3:0]  READ_ADDRESS = '0;
  logic [63:0] READ_DATA;
  logic        OP_START, OP_DATA_A_OUT_ENABLE, OP_DATA_B_OUT_ENABLE;
  logic [63:0] OP_SIZE_OUT, OP_DATA_A_OUT, OP_DATA_B_OUT;
  logic        OP_DATA_IN_ENABLE = 1'b0;
  logic [63:0] OP_DATA_IN = '0;

  model_vector_fixed_sequencer #(.DATA_SIZE(64), .CONTROL_SIZE(64), .ADDRESS_SIZE(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .BUSY(BUSY), .SIZE_IN(SIZE_IN),
    .LOAD_A_ENABLE(LOAD_A_ENABLE), .LOAD_B_ENABLE(LOAD_B_ENABLE),
    .LOAD_ADDRESS(LOAD_ADDRESS), .LOAD_DATA(LOAD_DATA),
    .READ_ADDRESS(READ_ADDRESS), .READ_DATA(READ_DATA),
    .OP_START(OP_START), .OP_SIZE_OUT(OP_SIZE_OUT),
    .OP_DATA_A_OUT_ENABLE(OP_DATA_A_OUT_ENABLE), .OP_DATA_B_OUT_ENABLE(OP_DATA_B_OUT_ENABLE),
    .OP_DATA_A_OUT(OP_DATA_A_OUT), .OP_DATA_B_OUT(OP_DATA_B_OUT),
    .OP_DATA_IN_ENABLE(OP_DATA_IN_ENABLE), .OP_DATA_IN(OP_DATA_IN)
  );

  always #5 CLK = ~CLK;

  // Vector-level model of the three arrays.
  logic [63:0] ma [16];
  logic [63:0] mb [16];
  logic [63:0] mres [16];

  // Observation / operator-model state.
  int          n_total = 0, n_bad = 0;
  int          cyc_n = 0;
  int          lat = 1;
  bit          spur_mode = 0, spur_next = 0, gap_chk = 0;
  int          n_opstart = 0, n_ready = 0, ready_cyc = 0, last_resp = -100;
  logic        ready_busy = 1'b0;
  logic [63:0] qa[$], qb[$], resp_val[$];
  int          resp_due[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // One clock: sample at the falling edge, then drive the operator side.
  task automatic step();
    @(negedge CLK);
    cyc_n++;
    if (OP_START) n_opstart++;
    if (OP_DATA_A_OUT_ENABLE) begin
      qa.push_back(OP_DATA_A_OUT);
      qb.push_back(OP_DATA_B_OUT);
      if (gap_chk && last_resp > 0) chk("pair_gap", 64'(cyc_n - last_resp), 64'd2);
      resp_due.push_back(cyc_n + lat);
      resp_val.push_back(OP_DATA_A_OUT / OP_DATA_B_OUT);
    end
    if (READY) begin
      n_ready++;
      ready_cyc  = cyc_n;
      ready_busy = BUSY;
    end
    OP_DATA_IN_ENABLE = 1'b0;
    if (resp_due.size() > 0 && resp_due[0] == cyc_n) begin
      OP_DATA_IN_ENABLE = 1'b1;
      OP_DATA_IN = resp_val.pop_front();
      void'(resp_due.pop_front());
      last_resp = cyc_n;
      spur_next = spur_mode;
    end else if (spur_next) begin
      OP_DATA_IN_ENABLE = 1'b1;
      OP_DATA_IN = 64'hDEAD_BEEF_0BAD_F00D;
      spur_next = 0;
    end
  endtask

  task automatic load_ab(input int addr, input logic [63:0] a, input logic [63:0] b);
    LOAD_A_ENABLE = 1'b1; LOAD_B_ENABLE = 1'b0;
    LOAD_ADDRESS = 4'(addr); LOAD_DATA = a;
    step();
    LOAD_A_ENABLE = 1'b0; LOAD_B_ENABLE = 1'b1; LOAD_DATA = b;
    step();
    LOAD_B_ENABLE = 1'b0;
    ma[addr] = a;
    mb[addr] = b;
  endtask

  task automatic run_vec(input logic [63:0] size, input int latency, input bit spur,
                         input int poke, input bit gap_check);
    int eff;
    eff = (size > 64'd16) ? 16 : int'(size);
    lat = latency; spur_mode = spur; spur_next = 0; gap_chk = gap_check;
    qa.delete(); qb.delete(); resp_due.delete(); resp_val.delete();
    n_opstart = 0; n_ready = 0; last_resp = -100;
    SIZE_IN = size; START = 1'b1;
    step();
    START = 1'b0; LOAD_A_ENABLE = 1'b0; LOAD_B_ENABLE = 1'b0;
    if (eff > 0) begin
      chk("busy_run", 64'(BUSY), 64'd1);
      chk("op_size", OP_SIZE_OUT, 64'(eff));
    end else begin
      chk("ready_zero", 64'(READY), 64'd1);
      chk("busy_zero", 64'(BUSY), 64'd0);
    end
    for (int k = 0; k < 600 && n_ready == 0; k++) begin
      if (k == poke) begin
        LOAD_A_ENABLE = 1'b1; LOAD_ADDRESS = 4'd0; LOAD_DATA = 64'hFF; START = 1'b1;
      end
      step();
      LOAD_A_ENABLE = 1'b0; START = 1'b0;
    end
    chk("ready_seen", 64'(n_ready > 0), 64'd1);
    step(); step();
    chk("ready_cnt", 64'(n_ready), 64'd1);
    chk("opstart_cnt", 64'(n_opstart), (eff > 0) ? 64'd1 : 64'd0);
    chk("pair_cnt", 64'(qa.size()), 64'(eff));
    for (int i = 0; i < eff && i < qa.size(); i++) begin
      chk("pair_a", qa[i], ma[i]);
      chk("pair_b", qb[i], mb[i]);
    end
    if (eff > 0) begin
      chk("ready_lat", 64'(ready_cyc - last_resp), 64'd1);
      chk("ready_busy", 64'(ready_busy), 64'd0);
    end
    for (int i = 0; i < eff; i++) mres[i] = ma[i] / mb[i];
    for (int i = 0; i < eff; i++) begin
      READ_ADDRESS = 4'(i);
      step();
      chk("read", READ_DATA, mres[i]);
    end
  endtask

  task automatic abort_run();
    int n;
    lat = 3; spur_mode = 0; gap_chk = 0;
    qa.delete(); qb.delete(); resp_due.delete(); resp_val.delete();
    SIZE_IN = 64'd5; START = 1'b1;
    step();
    START = 1'b0;
    for (int k = 0; k < 200 && qa.size() < 3; k++) step();
    chk("abort_reach", 64'(qa.size()), 64'd3);
    resp_due.delete(); resp_val.delete();
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_ctl", {59'd0, READY, BUSY, OP_START, OP_DATA_A_OUT_ENABLE, OP_DATA_B_OUT_ENABLE}, 64'd0);
    chk("rst_a", OP_DATA_A_OUT, 64'd0);
    chk("rst_b", OP_DATA_B_OUT, 64'd0);
    chk("rst_size", OP_SIZE_OUT, 64'd0);
    chk("rst_rd", READ_DATA, 64'd0);
    n = qa.size();
    repeat (12) step();
    chk("no_en_after_rst", 64'(qa.size()), 64'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    RST = 1'b0;
    chk("reset_ctl", {59'd0, READY, BUSY, OP_START, OP_DATA_A_OUT_ENABLE, OP_DATA_B_OUT_ENABLE}, 64'd0);
    chk("reset_data", OP_DATA_A_OUT | OP_DATA_B_OUT | OP_SIZE_OUT | READ_DATA, 64'd0);

    for (int i = 0; i < 16; i++) load_ab(i, {$urandom, $urandom}, 64'($urandom_range(1, 1000)));

    // Directed vector: results are A/B = 8 for every element.
    load_ab(0, 64'h10, 64'd2);
    load_ab(1, 64'h20, 64'd4);
    load_ab(2, 64'h30, 64'd6);
    run_vec(64'd3, 5, 0, -1, 0);

    run_vec(64'd0, 2, 0, -1, 0);
    run_vec(64'd20, 2, 0, -1, 0);
    run_vec(64'h1_0000_0003, 1, 0, -1, 0);
    run_vec(64'd4, 1, 1, -1, 1);
    run_vec(64'd6, 4, 0, 3, 0);
    run_vec(64'd1, 1, 0, -1, 1);

    // Load presented in the same cycle as START must be used by the run.
    LOAD_A_ENABLE = 1'b1; LOAD_ADDRESS = 4'd1; LOAD_DATA = 64'h1234_5678_9ABC_DEF0;
    ma[1] = 64'h1234_5678_9ABC_DEF0;
    run_vec(64'd3, 2, 0, -1, 1);

    abort_run();
    run_vec(64'd5, 2, 0, -1, 1);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 16; i++) load_ab(i, {$urandom, $urandom}, 64'($urandom_range(1, 5000)));
      run_vec(64'($urandom_range(1, 18)), int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), -1, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
